// File: rtl/sq_int_pkg.sv
// Shared types and helpers for the iterative squarer and its sqrt-side checkers.
// canon_ok is widened to MaxCanonW so callers of any width can zero-extend into it.
package sq_int_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StDone
   } sq_state_t;

   localparam int unsigned MaxCanonW = 64;

   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

   // Legal sqrt remainder: rem <= 2*root, compared one bit wider than the operands.
   function automatic logic canon_ok(input logic [MaxCanonW-1:0] root,
                                     input logic [MaxCanonW-1:0] rem);
      return ({1'b0, rem} <= {root, 1'b0});
   endfunction

endpackage

// File: rtl/sq_step.sv
// One radix-2 shift-add step of the squarer datapath (purely combinational).
module sq_step
   import sq_int_pkg::*;
#(
   parameter int unsigned DATAWIDTH = 8
) (
   input  logic [2*DATAWIDTH-1:0] acc_i,
   input  logic [2*DATAWIDTH-1:0] mcand_i,
   input  logic [DATAWIDTH-1:0]   mplier_i,
   output logic [2*DATAWIDTH-1:0] acc_o,
   output logic [2*DATAWIDTH-1:0] mcand_o,
   output logic [DATAWIDTH-1:0]   mplier_o
);

   always_comb begin
      acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
      mcand_o  = {mcand_i[2*DATAWIDTH-2:0], 1'b0};
      mplier_o = {1'b0, mplier_i[DATAWIDTH-1:1]};
   end

endmodule

// File: rtl/sq_int.sv
// Iterative integer squarer: rad = root*root + rem, one multiplier bit per cycle,
// with valid/ready handshakes on both sides and a registered canonical-remainder flag.
module sq_int
   import sq_int_pkg::*;
#(
   parameter int unsigned DATAWIDTH   = 8,
   parameter int unsigned INSTANCE_ID = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_valid,
   output logic                   i_ready,
   input  logic [DATAWIDTH-1:0]   root,
   input  logic [DATAWIDTH-1:0]   rem,
   output logic                   o_valid,
   input  logic                   o_ready,
   output logic [2*DATAWIDTH-1:0] rad,
   output logic                   canon
);

   localparam int unsigned CntW = cnt_width(DATAWIDTH);
   localparam int unsigned AccW = 2 * DATAWIDTH;

   sq_state_t state_q, state_d;

   logic [AccW-1:0]      acc_q, acc_d;
   logic [AccW-1:0]      mcand_q, mcand_d;
   logic [DATAWIDTH-1:0] mplier_q, mplier_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 canon_q, canon_d;

   logic [AccW-1:0]      step_acc;
   logic [AccW-1:0]      step_mcand;
   logic [DATAWIDTH-1:0] step_mplier;

   logic load;
   logic step_en;
   logic last_step;

   logic unused_instance_id;
   assign unused_instance_id = ^INSTANCE_ID;

   sq_step #(
      .DATAWIDTH (DATAWIDTH)
   ) u_step (
      .acc_i    (acc_q),
      .mcand_i  (mcand_q),
      .mplier_i (mplier_q),
      .acc_o    (step_acc),
      .mcand_o  (step_mcand),
      .mplier_o (step_mplier)
   );

   assign last_step = (cnt_q == CntW'(DATAWIDTH - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (i_valid) state_d = StCalc;
         end
         StCalc: begin
            if (last_step) state_d = StDone;
         end
         StDone: begin
            if (o_ready) state_d = i_valid ? StCalc : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Output / control decode; i_ready in DONE is the only input-to-output path.
   always_comb begin
      i_ready = 1'b0;
      o_valid = 1'b0;
      step_en = 1'b0;
      unique case (state_q)
         StIdle: i_ready = 1'b1;
         StCalc: step_en = 1'b1;
         StDone: begin
            o_valid = 1'b1;
            i_ready = o_ready;
         end
         default: ;
      endcase
   end

   assign load = i_valid & i_ready;

   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      canon_d  = canon_q;
      if (load) begin
         acc_d    = AccW'(rem);
         mcand_d  = AccW'(root);
         mplier_d = root;
         cnt_d    = '0;
         canon_d  = canon_ok(MaxCanonW'(root), MaxCanonW'(rem));
      end else if (step_en) begin
         acc_d    = step_acc;
         mcand_d  = step_mcand;
         mplier_d = step_mplier;
         cnt_d    = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         canon_q  <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         canon_q  <= canon_d;
      end
   end

   assign rad   = acc_q;
   assign canon = canon_q;

endmodule

// File: tb/tb_sq_int.sv
// Self-checking bench for sq_int (DATAWIDTH=8): vector table, scoreboard, corner sequences.
module tb_sq_int;

   localparam int unsigned DW = 8;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          i_valid = 1'b0;
   logic          o_ready = 1'b0;
   logic [DW-1:0] root    = '0;
   logic [DW-1:0] rem     = '0;
   logic          i_ready;
   logic          o_valid;
   logic          canon;
   logic [2*DW-1:0] rad;

   sq_int #(
      .DATAWIDTH   (DW),
      .INSTANCE_ID (3)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .root    (root),
      .rem     (rem),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .rad     (rad),
      .canon   (canon)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2*DW-1:0] rad;
      logic            canon;
      int              acc_cyc;
   } exp_t;

   typedef struct {
      logic [DW-1:0]   root;
      logic [DW-1:0]   rem;
      logic [2*DW-1:0] rad;
      logic            canon;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[8];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit head_seen = 1'b0;
   bit acc_fire;
   bit out_fire;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Drive inputs on the falling edge, sample 1ns later, update the scoreboard.
   task automatic step(input logic v, input logic [DW-1:0] r, input logic [DW-1:0] m,
                       input logic ordy, input logic [2*DW-1:0] erad, input logic ecanon);
      @(negedge clk);
      i_valid = v;
      root    = r;
      rem     = m;
      o_ready = ordy;
      #1;
      cyc++;
      acc_fire = i_valid && i_ready;
      out_fire = o_valid && o_ready;
      if (exp_q.size() == 0) begin
         check("no_spurious_valid", {31'd0, o_valid}, 32'd0);
      end else if (!o_valid) begin
         check("i_ready_low_in_calc", {31'd0, i_ready}, 32'd0);
      end else begin
         if (!head_seen) begin
            head_seen = 1'b1;
            check("latency", cyc - exp_q[0].acc_cyc, DW + 1);
         end
         check("rad", {16'd0, rad}, {16'd0, exp_q[0].rad});
         check("canon", {31'd0, canon}, {31'd0, exp_q[0].canon});
         if (!o_ready) check("i_ready_backpressure", {31'd0, i_ready}, 32'd0);
         if (o_ready) begin
            void'(exp_q.pop_front());
            head_seen = 1'b0;
         end
      end
      if (acc_fire) exp_q.push_back('{erad, ecanon, cyc});
   endtask

   task automatic send(input logic [DW-1:0] r, input logic [DW-1:0] m,
                       input logic [2*DW-1:0] erad, input logic ecanon);
      bit done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         step(1'b1, r, m, 1'b1, erad, ecanon);
         done = acc_fire;
      end
      check("accept_timeout", {31'd0, done}, 32'd1);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
         step(1'b0, '0, '0, 1'b1, '0, 1'b0);
      end
      check("drain_timeout", exp_q.size(), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int r;
      int steps;
      bit seen;

      vecs[0] = '{8'd15,  8'd0,   16'd225,   1'b1};
      vecs[1] = '{8'd0,   8'd0,   16'd0,     1'b1};
      vecs[2] = '{8'd12,  8'd24,  16'd168,   1'b1};
      vecs[3] = '{8'd12,  8'd25,  16'd169,   1'b0};
      vecs[4] = '{8'd255, 8'd255, 16'd65280, 1'b1};
      vecs[5] = '{8'd1,   8'd3,   16'd4,     1'b0};
      vecs[6] = '{8'd1,   8'd2,   16'd3,     1'b1};
      vecs[7] = '{8'd200, 8'd17,  16'd40017, 1'b1};

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("reset_i_ready", {31'd0, i_ready}, 32'd1);
      check("reset_o_valid", {31'd0, o_valid}, 32'd0);
      check("reset_rad", {16'd0, rad}, 32'd0);
      check("reset_canon", {31'd0, canon}, 32'd0);
      rst_n = 1'b1;

      // Vector table
      for (int i = 0; i < 8; i++) begin
         send(vecs[i].root, vecs[i].rem, vecs[i].rad, vecs[i].canon);
         drain(30);
      end

      // Backpressure then back-to-back accept in DONE
      send(8'd100, 8'd50, 16'd10050, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step(1'b0, '0, '0, 1'b0, '0, 1'b0);
         seen = o_valid;
      end
      check("bp_valid_timeout", {31'd0, seen}, 32'd1);
      repeat (5) step(1'b0, '0, '0, 1'b0, '0, 1'b0);
      step(1'b1, 8'd7, 8'd3, 1'b1, 16'd52, 1'b1);
      check("b2b_accept", {31'd0, acc_fire}, 32'd1);
      check("b2b_out_fire", {31'd0, out_fire}, 32'd1);
      drain(30);

      // Asynchronous reset three cycles into CALC
      send(8'd200, 8'd100, 16'd40100, 1'b1);
      repeat (3) step(1'b0, '0, '0, 1'b1, '0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_o_valid", {31'd0, o_valid}, 32'd0);
      check("midreset_rad", {16'd0, rad}, 32'd0);
      check("midreset_canon", {31'd0, canon}, 32'd0);
      check("midreset_i_ready", {31'd0, i_ready}, 32'd1);
      exp_q.delete();
      head_seen = 1'b0;
      repeat (2) step(1'b0, '0, '0, 1'b1, '0, 1'b0);
      #2;
      rst_n = 1'b1;
      repeat (15) step(1'b0, '0, '0, 1'b1, '0, 1'b0);
      check("post_reset_i_ready", {31'd0, i_ready}, 32'd1);
      send(8'd3, 8'd4, 16'd13, 1'b1);
      drain(30);

      // Round trip of every sqrt result for radicands 0..255, streamed back-to-back
      n = 0;
      steps = 0;
      for (int guard = 0; guard < 5000 && n < 256; guard++) begin
         r = 0;
         while ((r + 1) * (r + 1) <= n) r++;
         step(1'b1, DW'(r), DW'(n - r * r), 1'b1, 16'(n), 1'b1);
         steps++;
         if (acc_fire) n++;
      end
      check("roundtrip_fed", n, 32'd256);
      check("roundtrip_throughput", steps, 32'd2296);
      drain(30);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
